// File: rtl/img_mem_scheduler_if.sv
// Engine-side access bus for img_mem_scheduler: a held request with a
// one-cycle grant, plus a read-data strobe that arrives two cycles after the grant.
interface img_mem_if;
    logic        eng_req;
    logic        eng_we;
    logic [15:0] eng_addr;
    logic [2:0]  eng_wdata;
    logic        eng_gnt;
    logic        eng_rvalid;
    logic [2:0]  eng_rdata;

    modport master (
        output eng_req, eng_we, eng_addr, eng_wdata,
        input  eng_gnt, eng_rvalid, eng_rdata
    );

    modport slave (
        input  eng_req, eng_we, eng_addr, eng_wdata,
        output eng_gnt, eng_rvalid, eng_rdata
    );
endinterface

// File: rtl/img_mem_scheduler.sv
// Shares one single-port 64Kx3 image RAM between the VGA display fetch, which
// has priority, and the equalizer engine. Engine passes may only start at vertical blank.
module img_mem_scheduler #(
    parameter int IMG_X0   = 126,
    parameter int IMG_Y0   = 151,
    parameter int IMG_W    = 254,
    parameter int IMG_H    = 254,
    parameter int V_ACTIVE = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_tick,
    input  logic [9:0]  X,
    input  logic [9:0]  Y,
    output logic [2:0]  disp_pixel,
    output logic        disp_in_img,
    img_mem_if.slave    eng,
    input  logic        pass_req,
    output logic        pass_go,
    input  logic        pass_done,
    output logic        busy,
    output logic [15:0] mem_addr,
    output logic        mem_we,
    output logic [2:0]  mem_wdata,
    input  logic [2:0]  mem_rdata
);
    localparam logic [9:0] X_LO  = 10'(IMG_X0);
    localparam logic [9:0] X_HI  = 10'(IMG_X0 + IMG_W);
    localparam logic [9:0] Y_LO  = 10'(IMG_Y0);
    localparam logic [9:0] Y_HI  = 10'(IMG_Y0 + IMG_H);
    localparam logic [9:0] V_ACT = 10'(V_ACTIVE);

    typedef enum logic [1:0] {IDLE, ARMED, RUN} pass_state_t;

    pass_state_t state, state_nxt;
    logic        disp_cyc;
    logic [15:0] disp_addr;
    logic [15:0] addr_q;
    logic        disp_rd_q;
    logic        blank_tick_q;
    logic        eng_rd_q;
    logic [9:0]  y_prev;
    logic        vb_rise;

    assign disp_cyc  = pix_tick && (X >= X_LO) && (X < X_HI) && (Y >= Y_LO) && (Y < Y_HI);
    assign disp_addr = {8'(Y - Y_LO), 8'(X - X_LO)};
    assign vb_rise   = (Y >= V_ACT) && (y_prev < V_ACT);
    assign busy      = (state != IDLE);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        mem_addr    = addr_q;
        mem_we      = 1'b0;
        mem_wdata   = '0;
        eng.eng_gnt = 1'b0;
        if (disp_cyc) begin
            mem_addr = disp_addr;
        end else if (eng.eng_req) begin
            eng.eng_gnt = 1'b1;
            mem_addr    = eng.eng_addr;
            mem_we      = eng.eng_we;
            mem_wdata   = eng.eng_wdata;
        end
    end

    always_comb begin
        state_nxt = state;
        pass_go   = 1'b0;
        case (state)
            IDLE:    if (pass_req) state_nxt = ARMED;
            ARMED:   if (vb_rise) begin
                         state_nxt = RUN;
                         pass_go   = 1'b1;
                     end
            RUN:     if (pass_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            addr_q         <= '0;
            disp_rd_q      <= 1'b0;
            blank_tick_q   <= 1'b0;
            eng_rd_q       <= 1'b0;
            y_prev         <= '0;
            disp_pixel     <= '0;
            disp_in_img    <= 1'b0;
            eng.eng_rvalid <= 1'b0;
            eng.eng_rdata  <= '0;
        end else begin
            state        <= state_nxt;
            addr_q       <= mem_addr;
            y_prev       <= Y;
            disp_rd_q    <= disp_cyc;
            blank_tick_q <= pix_tick && !disp_cyc;
            eng_rd_q     <= eng.eng_gnt && !eng.eng_we;

            // RAM data for an access issued last cycle is valid now; capture it for its owner
            if (disp_rd_q) begin
                disp_pixel  <= mem_rdata;
                disp_in_img <= 1'b1;
            end else if (blank_tick_q) begin
                disp_in_img <= 1'b0;
            end

            eng.eng_rvalid <= eng_rd_q;
            if (eng_rd_q) eng.eng_rdata <= mem_rdata;
        end
    end
endmodule
